// File: rtl/keypad_tx_if.sv
// Keypad-side bus of keypad_tx: row sense, column drive and the calculator
// data/strobe outputs. "master" is the keypad_tx side, "slave" the consumer/keypad side.
interface keypad_tx_if;
    logic [3:0] rows;
    logic [3:0] cols;
    logic [7:0] data;
    logic       validate;
    logic       key_down;

    modport master (input rows, output cols, data, validate, key_down);
    modport slave  (output rows, input cols, data, validate, key_down);
endinterface

// File: rtl/keypad_tx.sv
// 4x4 keypad scanner with press/release debounce and an active-low validate strobe per key.
// Optional auto-repeat while a key is held is built only with KEYPAD_TX_AUTOREPEAT_EN defined.
module keypad_tx #(
    parameter int CLK_DIV            = 50000,
    parameter int DEBOUNCE_SCANS     = 10,
    parameter int PULSE_LEN          = 4,
    parameter int REPEAT_DELAY_SCANS = 500,
    parameter int REPEAT_RATE_SCANS  = 100
) (
    input  logic         CLOCK_50,
    input  logic         RESET_N,
    keypad_tx_if.master  kp
);
    localparam int DIV_W   = $clog2(CLK_DIV + 1);
    localparam int PULSE_W = $clog2(PULSE_LEN + 1);
    localparam int CNT_MAX = (DEBOUNCE_SCANS > REPEAT_DELAY_SCANS)
                           ? ((DEBOUNCE_SCANS > REPEAT_RATE_SCANS) ? DEBOUNCE_SCANS : REPEAT_RATE_SCANS)
                           : ((REPEAT_DELAY_SCANS > REPEAT_RATE_SCANS) ? REPEAT_DELAY_SCANS : REPEAT_RATE_SCANS);
    localparam int CNT_W   = $clog2(CNT_MAX + 1);

    typedef enum logic [2:0] {IDLE, PRESS_DEB, SETUP, STROBE, HOLD, REL_DEB} state_t;

    function automatic logic [7:0] key_code(input logic [3:0] idx);
        case (idx)
            4'd0:  key_code = 8'd1;   4'd1:  key_code = 8'd2;
            4'd2:  key_code = 8'd3;   4'd3:  key_code = 8'd15;
            4'd4:  key_code = 8'd4;   4'd5:  key_code = 8'd5;
            4'd6:  key_code = 8'd6;   4'd7:  key_code = 8'd19;
            4'd8:  key_code = 8'd7;   4'd9:  key_code = 8'd8;
            4'd10: key_code = 8'd9;   4'd11: key_code = 8'd12;
            4'd12: key_code = 8'd18;  4'd13: key_code = 8'd0;
            4'd14: key_code = 8'd16;  default: key_code = 8'd26;
        endcase
    endfunction

    logic [DIV_W-1:0] r_div;
    logic [1:0]       r_col;
    logic [3:0]       r_rows_m, r_rows_s;
    logic [15:0]      r_acc, r_snap;
    logic             r_snap_vld;
    logic             w_slot_end;
    logic [15:0]      w_acc_next;

    assign w_slot_end = (r_div == DIV_W'(CLK_DIV - 1));
    assign kp.cols    = ~(4'b0001 << r_col);

    // Column c of the current slot is filled from the synchronized rows; a new scan starts from zero.
    for (genvar gi = 0; gi < 16; gi++) begin : g_acc
        assign w_acc_next[gi] = (r_col == 2'(gi % 4)) ? ~r_rows_s[gi / 4]
                              : ((r_col == 2'd0) ? 1'b0 : r_acc[gi]);
    end

    always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
        if (!RESET_N) begin
            r_div      <= '0;
            r_col      <= 2'd0;
            r_rows_m   <= 4'hF;   // synchronizers cleared to the released (pulled-up) level
            r_rows_s   <= 4'hF;
            r_acc      <= '0;
            r_snap     <= '0;
            r_snap_vld <= 1'b0;
        end else begin
            r_rows_m   <= kp.rows;
            r_rows_s   <= r_rows_m;
            r_snap_vld <= 1'b0;
            if (w_slot_end) begin
                r_div <= '0;
                r_col <= r_col + 2'd1;
                r_acc <= w_acc_next;
                if (r_col == 2'd3) begin
                    r_snap     <= w_acc_next;
                    r_snap_vld <= 1'b1;
                end
            end else begin
                r_div <= r_div + DIV_W'(1);
            end
        end
    end

    logic       w_onehot;
    logic [3:0] w_idx;

    assign w_onehot = (r_snap != 16'd0) && ((r_snap & (r_snap - 16'd1)) == 16'd0);

    always_comb begin
        w_idx = 4'd0;
        for (int i = 0; i < 16; i++)
            if (r_snap[i]) w_idx = 4'(i);
    end

    state_t             r_state, w_state_next;
    logic [3:0]         r_key, w_key_next;
    logic [CNT_W-1:0]   r_cnt, w_cnt_next;
    logic [PULSE_W-1:0] r_pulse, w_pulse_next;
    logic [7:0]         r_data;
    logic               r_validate, r_key_down, w_key_down_next;
`ifdef KEYPAD_TX_AUTOREPEAT_EN
    logic               r_rep, w_rep_next;
`endif

    always_comb begin
        w_state_next    = r_state;
        w_key_next      = r_key;
        w_cnt_next      = r_cnt;
        w_pulse_next    = r_pulse;
        w_key_down_next = r_key_down;
`ifdef KEYPAD_TX_AUTOREPEAT_EN
        w_rep_next      = r_rep;
`endif
        case (r_state)
            IDLE: if (r_snap_vld && w_onehot) begin
                w_state_next = PRESS_DEB;
                w_key_next   = w_idx;
                w_cnt_next   = '0;
            end
            PRESS_DEB: if (r_snap_vld) begin
                if (!w_onehot) begin
                    w_state_next = IDLE;
                end else if (w_idx != r_key) begin
                    w_key_next = w_idx;
                    w_cnt_next = '0;
                end else if (r_cnt == CNT_W'(DEBOUNCE_SCANS - 1)) begin
                    w_state_next = SETUP;
`ifdef KEYPAD_TX_AUTOREPEAT_EN
                    w_rep_next   = 1'b0;
`endif
                end else begin
                    w_cnt_next = r_cnt + CNT_W'(1);
                end
            end
            SETUP: begin
                w_state_next    = STROBE;
                w_pulse_next    = '0;
                w_key_down_next = 1'b1;
            end
            STROBE: if (r_pulse == PULSE_W'(PULSE_LEN - 1)) begin
                w_state_next = HOLD;
                w_cnt_next   = '0;
            end else begin
                w_pulse_next = r_pulse + PULSE_W'(1);
            end
            HOLD: if (r_snap_vld) begin
                if (r_snap == 16'd0) begin
                    w_state_next = REL_DEB;
                    w_cnt_next   = '0;
                end
`ifdef KEYPAD_TX_AUTOREPEAT_EN
                // On_Off toggles power, so it must never auto-repeat.
                else if (w_onehot && w_idx == r_key && key_code(r_key) != 8'd18) begin
                    if (r_cnt == CNT_W'((r_rep ? REPEAT_RATE_SCANS : REPEAT_DELAY_SCANS) - 1)) begin
                        w_state_next = SETUP;
                        w_rep_next   = 1'b1;
                    end else begin
                        w_cnt_next = r_cnt + CNT_W'(1);
                    end
                end else begin
                    w_cnt_next = '0;
                end
`endif
            end
            REL_DEB: if (r_snap_vld) begin
                if (r_snap != 16'd0) begin
                    w_state_next = HOLD;
                    w_cnt_next   = '0;
                end else if (r_cnt == CNT_W'(DEBOUNCE_SCANS - 1)) begin
                    w_state_next    = IDLE;
                    w_key_down_next = 1'b0;
                end else begin
                    w_cnt_next = r_cnt + CNT_W'(1);
                end
            end
            default: w_state_next = IDLE;
        endcase
    end

    always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
        if (!RESET_N) begin
            r_state    <= IDLE;
            r_key      <= 4'd0;
            r_cnt      <= '0;
            r_pulse    <= '0;
            r_data     <= 8'd0;
            r_validate <= 1'b1;
            r_key_down <= 1'b0;
`ifdef KEYPAD_TX_AUTOREPEAT_EN
            r_rep      <= 1'b0;
`endif
        end else begin
            r_state    <= w_state_next;
            r_key      <= w_key_next;
            r_cnt      <= w_cnt_next;
            r_pulse    <= w_pulse_next;
            r_key_down <= w_key_down_next;
            r_validate <= (w_state_next != STROBE);
            if (w_state_next == SETUP)
                r_data <= key_code(w_key_next);
`ifdef KEYPAD_TX_AUTOREPEAT_EN
            r_rep      <= w_rep_next;
`endif
        end
    end

    assign kp.data     = r_data;
    assign kp.validate = r_validate;
    assign kp.key_down = r_key_down;
endmodule
